data_sram_responder: RTL and testbench
======================================

Name: data_sram_responder

Overview:
- Memory-side responder for the CPU's request/response data memory interface (req/addr_ok/data_ok). The CPU top is the initiator.
- Backs requests with an internal byte-writable 32-bit word array.
- Inserts run-time-programmable address and data wait states, so the multi-cycle core can be exercised against non-ideal memory timing.
- Exactly one transaction outstanding at a time.

Parameters:
- ADDR_W, 12, log2 of array depth in 32-bit words (4096 words = 16 KiB).
- INIT_ZERO, 1, when 1 the array powers up to all-zero (simulation only; reset never clears the array).

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  1  request valid; initiator holds it and all request fields stable until addr_ok
- wr  in  1  1 = write, 0 = read
- size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved (treated as misaligned)
- wstrb  in  4  byte enables for writes; ignored on reads
- addr  in  32  byte address
- wdata  in  32  write data, byte lanes aligned to addr[1:0]
- cfg_addr_dly  in  4  address wait states; sampled on the first req cycle in IDLE
- cfg_data_dly  in  4  data wait states; sampled at acceptance
- addr_ok  out  1  request accepted this cycle (when req=1)
- data_ok  out  1  single-cycle response pulse, for reads and writes
- rdata  out  32  whole aligned word; valid only while data_ok=1
- err  out  1  sticky misalignment flag

Behaviour:
- States: IDLE, AWAIT, DWAIT. Encoding lives in the shared package.
- Reset (synchronous):
  - State goes to IDLE; counters clear.
  - addr_ok=0, data_ok=0, rdata=0, err=0 on the cycle after reset is sampled.
  - Array contents are unchanged.
  - Reset asserted mid-transaction abandons it; no data_ok is ever produced for it.
- Acceptance: the transaction is accepted on a clock edge where req=1 and addr_ok=1.
- IDLE:
  - req=1 and cfg_addr_dly==0: addr_ok=1 combinationally; accept.
  - req=1 and cfg_addr_dly=N>0: addr_ok=0; go to AWAIT with cnt=N-1.
- AWAIT:
  - addr_ok=1 when cnt==0; otherwise cnt decrements.
  - Net effect: acceptance happens exactly N cycles after the first req cycle.
  - req dropping in AWAIT is a protocol violation; the responder still accepts when cnt reaches 0.
- On accept:
  - Latch wr and the word index addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses alias.
  - Latch cfg_data_dly=M into cnt; go to DWAIT.
  - Writes commit to the array at the accept edge under wstrb.
  - Reads sample the array after any same-edge write, so read-after-write to the same address returns the new data.
- DWAIT:
  - data_ok=1 and rdata=latched word when cnt==0; otherwise cnt decrements.
  - Accept-to-data_ok latency is M+1 cycles (minimum 1).
  - rdata for writes is 0.
- Back-to-back: the data_ok cycle behaves as IDLE for the request path.
  - A pending req with cfg_addr_dly==0 gets addr_ok in the same cycle, re-entering DWAIT.
  - Otherwise go to AWAIT or IDLE as in IDLE.
  - addr_ok is never asserted in DWAIT while cnt!=0.
- Misalignment:
  - Misaligned means: size=1 with addr[0]=1, size=2 with addr[1:0]!=0, or size=3.
  - The request is still accepted and data_ok is still produced.
  - Write is suppressed, rdata=0, and err sets to 1, held until reset.
- size is used only for the alignment check. Byte selection is wstrb's job, and the CPU extracts bytes from rdata.
- Counter arithmetic is 4-bit unsigned; no wrap is possible because it only decrements to 0.

Decomposition:
- Shared package:
  - State encoding (IDLE=2'd0, AWAIT=2'd1, DWAIT=2'd2).
  - Size codes (SZ_B, SZ_H, SZ_W).
  - Misalignment check as a function.
- One sub-module: data_sram_array.
  - Byte-enable 32-bit array, depth 2**ADDR_W.
  - Synchronous write, combinational read with write-first forwarding.
  - Ports: clk, we, wstrb, idx, wdata, rdata.
- FSM, counter, response register and err live in the top.

Test Plan:
1. cfg_addr_dly=0, cfg_data_dly=0; word write of 0x12345678 to 0x0000_0010, then read 0x10 -> addr_ok in the same cycle as req; data_ok 1 cycle after each accept; read rdata=0x12345678; err=0.
2. cfg_addr_dly=3, cfg_data_dly=2; read -> addr_ok exactly 3 cycles after req rises; data_ok exactly 3 cycles after accept; data_ok is 1 cycle wide.
3. Word 0xFFFFFFFF at 0x20, then byte write wstrb=4'b0100, wdata=0x00AB0000, then read 0x20 -> rdata=0xFFABFFFF.
4. Back-to-back with both delays 0: read held pending during the previous data_ok cycle -> addr_ok coincides with data_ok, with no idle cycle between transactions.
5. size=2 at addr 0x22, wr=1 -> accepted; data_ok follows; word at 0x20 unchanged; err=1 and stays set; reset clears err to 0.
6. Reset asserted during DWAIT (cfg_data_dly=5) -> no data_ok; the next request starts cleanly from IDLE; earlier written data is still readable.

Source files
------------

// File: rtl/data_sram_responder_pkg.sv
// data_sram_responder_pkg: FSM state encoding, access size codes and alignment check shared by the responder.
package data_sram_responder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        AWAIT = 2'd1,
        DWAIT = 2'd2
    } state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Size code 3 is reserved and always reported as misaligned.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        return (size == SZ_H) ? a[0] : (size == SZ_W) ? (a != 2'b00) : (size != SZ_B);
    endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// data_sram_responder_if: CPU data-memory request/response bus plus wait-state configuration.
interface data_sram_responder_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  cfg_addr_dly;
    logic [3:0]  cfg_data_dly;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, wr, size, wstrb, addr, wdata, cfg_addr_dly, cfg_data_dly,
        input  addr_ok, data_ok, rdata, err
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata, cfg_addr_dly, cfg_data_dly,
        output addr_ok, data_ok, rdata, err
    );
endinterface

// File: rtl/data_sram_responder_array.sv
// data_sram_array: byte-writable 32-bit word store, synchronous write and write-first combinational read.
module data_sram_array #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        wstrb,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (we && wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end

    always_comb begin
        rdata = mem[idx];
        for (int b = 0; b < 4; b++)
            if (we && wstrb[b]) rdata[8*b +: 8] = wdata[8*b +: 8];
    end

endmodule

// File: rtl/data_sram_responder.sv
// data_sram_responder: single-outstanding data memory responder with programmable address/data wait states.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    data_sram_responder_if.slave bus
);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] arr_rdata;
    logic        free, data_ok, addr_ok, mis, we;
    logic        unused_addr;

    // The data_ok cycle doubles as an idle cycle so back-to-back requests lose no cycle.
    assign data_ok = (state_q == DWAIT) && (cnt_q == 4'd0);
    assign free    = (state_q == IDLE) || data_ok;
    assign addr_ok = (free && bus.req && bus.cfg_addr_dly == 4'd0) || (state_q == AWAIT && cnt_q == 4'd0);
    assign mis     = misaligned(bus.size, bus.addr[1:0]);
    assign we      = addr_ok && bus.wr && !mis;
    assign unused_addr = ^bus.addr[31:ADDR_W+2];

    data_sram_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .we    (we),
        .wstrb (bus.wstrb),
        .idx   (bus.addr[ADDR_W+1:2]),
        .wdata (bus.wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= err_q | (addr_ok & mis);
            if (addr_ok) begin
                state_q <= DWAIT;
                cnt_q   <= bus.cfg_data_dly;
                rdata_q <= (bus.wr || mis) ? '0 : arr_rdata;
            end else if (free && bus.req) begin
                state_q <= AWAIT;
                cnt_q   <= bus.cfg_addr_dly - 4'd1;
            end else if (free) begin
                state_q <= IDLE;
            end else if (cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    assign bus.addr_ok = addr_ok;
    assign bus.data_ok = data_ok;
    assign bus.rdata   = data_ok ? rdata_q : '0;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: directed scenario bench for the data memory responder.
module tb_data_sram_responder;
    import data_sram_responder_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   al, dl, cnt;
    logic [31:0] rd;
    logic da;

    data_sram_responder_if bus ();

    data_sram_responder #(.ADDR_W(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic xact(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [3:0] st,
                        input logic [31:0] wd, output int alat, output int dlat, output logic [31:0] rdv,
                        output logic dok_after);
        @(posedge clk); #1;
        bus.req = 1'b1; bus.wr = w; bus.size = sz; bus.addr = a; bus.wstrb = st; bus.wdata = wd;
        alat = -1; dlat = -1; rdv = 32'hxxxxxxxx; dok_after = 1'bx;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.addr_ok === 1'b1) begin alat = k; break; end
        end
        @(posedge clk); #1;
        bus.req = 1'b0;
        if (alat >= 0) begin
            for (int j = 1; j < 40; j++) begin
                @(negedge clk);
                if (bus.data_ok === 1'b1) begin dlat = j; rdv = bus.rdata; break; end
            end
            @(negedge clk);
            dok_after = bus.data_ok;
        end
    endtask

    task automatic test_reset;
        bus.req = 1'b0; bus.wr = 1'b0; bus.size = SZ_W; bus.addr = '0; bus.wstrb = '0; bus.wdata = '0;
        bus.cfg_addr_dly = 4'd0; bus.cfg_data_dly = 4'd0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        tests++; if (bus.addr_ok !== 1'b0) begin fails++; $display("FAIL reset_addr_ok got %b want 0", bus.addr_ok); end
        tests++; if (bus.data_ok !== 1'b0) begin fails++; $display("FAIL reset_data_ok got %b want 0", bus.data_ok); end
        tests++; if (bus.rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", bus.rdata); end
        tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", bus.err); end
    endtask

    task automatic test_basic;
        bus.cfg_addr_dly = 4'd0; bus.cfg_data_dly = 4'd0;
        xact(1'b1, SZ_W, 32'h10, 4'hF, 32'h12345678, al, dl, rd, da);
        tests++; if (al !== 0) begin fails++; $display("FAIL basic_wr_alat got %0d want 0", al); end
        tests++; if (dl !== 1) begin fails++; $display("FAIL basic_wr_dlat got %0d want 1", dl); end
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL basic_wr_rdata got %h want 0", rd); end
        tests++; if (da !== 1'b0) begin fails++; $display("FAIL basic_wr_width got %b want 0", da); end
        xact(1'b0, SZ_W, 32'h10, 4'h0, 32'h0, al, dl, rd, da);
        tests++; if (al !== 0) begin fails++; $display("FAIL basic_rd_alat got %0d want 0", al); end
        tests++; if (dl !== 1) begin fails++; $display("FAIL basic_rd_dlat got %0d want 1", dl); end
        tests++; if (rd !== 32'h12345678) begin fails++; $display("FAIL basic_rd_rdata got %h want 12345678", rd); end
        tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL basic_err got %b want 0", bus.err); end
        xact(1'b0, SZ_W, 32'h4010, 4'h0, 32'h0, al, dl, rd, da);
        tests++; if (rd !== 32'h12345678) begin fails++; $display("FAIL alias_rdata got %h want 12345678", rd); end
    endtask

    task automatic test_wait_states;
        bus.cfg_addr_dly = 4'd3; bus.cfg_data_dly = 4'd2;
        xact(1'b0, SZ_W, 32'h10, 4'h0, 32'h0, al, dl, rd, da);
        tests++; if (al !== 3) begin fails++; $display("FAIL wait_alat got %0d want 3", al); end
        tests++; if (dl !== 3) begin fails++; $display("FAIL wait_dlat got %0d want 3", dl); end
        tests++; if (da !== 1'b0) begin fails++; $display("FAIL wait_width got %b want 0", da); end
        tests++; if (rd !== 32'h12345678) begin fails++; $display("FAIL wait_rdata got %h want 12345678", rd); end
        bus.cfg_addr_dly = 4'd0; bus.cfg_data_dly = 4'd0;
    endtask

    task automatic test_byte_write;
        xact(1'b1, SZ_W, 32'h20, 4'hF, 32'hFFFFFFFF, al, dl, rd, da);
        xact(1'b1, SZ_B, 32'h22, 4'b0100, 32'h00AB0000, al, dl, rd, da);
        tests++; if (dl !== 1) begin fails++; $display("FAIL byte_wr_dlat got %0d want 1", dl); end
        xact(1'b0, SZ_W, 32'h20, 4'h0, 32'h0, al, dl, rd, da);
        tests++; if (rd !== 32'hFFABFFFF) begin fails++; $display("FAIL byte_rdata got %h want ffabffff", rd); end
    endtask

    task automatic test_back_to_back;
        @(posedge clk); #1;
        bus.req = 1'b1; bus.wr = 1'b0; bus.size = SZ_W; bus.addr = 32'h10;
        @(negedge clk);
        tests++; if (bus.addr_ok !== 1'b1) begin fails++; $display("FAIL b2b_first_addr_ok got %b want 1", bus.addr_ok); end
        @(posedge clk); #1;
        bus.addr = 32'h20;
        @(negedge clk);
        tests++; if (bus.data_ok !== 1'b1) begin fails++; $display("FAIL b2b_first_data_ok got %b want 1", bus.data_ok); end
        tests++; if (bus.addr_ok !== 1'b1) begin fails++; $display("FAIL b2b_overlap_addr_ok got %b want 1", bus.addr_ok); end
        tests++; if (bus.rdata !== 32'h12345678) begin fails++; $display("FAIL b2b_first_rdata got %h want 12345678", bus.rdata); end
        @(posedge clk); #1;
        bus.req = 1'b0;
        @(negedge clk);
        tests++; if (bus.data_ok !== 1'b1) begin fails++; $display("FAIL b2b_second_data_ok got %b want 1", bus.data_ok); end
        tests++; if (bus.addr_ok !== 1'b0) begin fails++; $display("FAIL b2b_second_addr_ok got %b want 0", bus.addr_ok); end
        tests++; if (bus.rdata !== 32'hFFABFFFF) begin fails++; $display("FAIL b2b_second_rdata got %h want ffabffff", bus.rdata); end
        @(negedge clk);
        tests++; if (bus.data_ok !== 1'b0) begin fails++; $display("FAIL b2b_tail_data_ok got %b want 0", bus.data_ok); end
    endtask

    task automatic test_misaligned;
        xact(1'b1, SZ_W, 32'h22, 4'hF, 32'hDEADBEEF, al, dl, rd, da);
        tests++; if (al !== 0) begin fails++; $display("FAIL mis_alat got %0d want 0", al); end
        tests++; if (dl !== 1) begin fails++; $display("FAIL mis_dlat got %0d want 1", dl); end
        tests++; if (bus.err !== 1'b1) begin fails++; $display("FAIL mis_err got %b want 1", bus.err); end
        xact(1'b0, SZ_W, 32'h20, 4'h0, 32'h0, al, dl, rd, da);
        tests++; if (rd !== 32'hFFABFFFF) begin fails++; $display("FAIL mis_unchanged got %h want ffabffff", rd); end
        tests++; if (bus.err !== 1'b1) begin fails++; $display("FAIL mis_err_sticky got %b want 1", bus.err); end
        xact(1'b0, 2'd3, 32'h20, 4'h0, 32'h0, al, dl, rd, da);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL mis_rsvd_rdata got %h want 0", rd); end
        xact(1'b0, SZ_H, 32'h21, 4'h0, 32'h0, al, dl, rd, da);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL mis_half_rdata got %h want 0", rd); end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL mis_err_cleared got %b want 0", bus.err); end
    endtask

    task automatic test_reset_mid;
        bus.cfg_addr_dly = 4'd0; bus.cfg_data_dly = 4'd5;
        @(posedge clk); #1;
        bus.req = 1'b1; bus.wr = 1'b0; bus.size = SZ_W; bus.addr = 32'h10;
        @(negedge clk);
        tests++; if (bus.addr_ok !== 1'b1) begin fails++; $display("FAIL rmid_addr_ok got %b want 1", bus.addr_ok); end
        @(posedge clk); #1 bus.req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        bus.cfg_data_dly = 4'd0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.data_ok !== 1'b0) cnt++;
        end
        tests++; if (cnt !== 0) begin fails++; $display("FAIL rmid_no_data_ok got %0d want 0", cnt); end
        xact(1'b0, SZ_W, 32'h10, 4'h0, 32'h0, al, dl, rd, da);
        tests++; if (al !== 0) begin fails++; $display("FAIL rmid_alat got %0d want 0", al); end
        tests++; if (dl !== 1) begin fails++; $display("FAIL rmid_dlat got %0d want 1", dl); end
        tests++; if (rd !== 32'h12345678) begin fails++; $display("FAIL rmid_rdata got %h want 12345678", rd); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_wait_states;
        test_byte_write;
        test_back_to_back;
        test_misaligned;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
